// File: rtl/speaker_pkg.sv
// Shared note-code definitions for the music player datapath.
package speaker_pkg;

  localparam logic [7:0] NOTE_REST = 8'h00;
  localparam logic [7:0] NOTE_END  = 8'hFF;

  function automatic logic is_sounding(input logic [7:0] note);
    return (note != NOTE_REST) && (note != NOTE_END);
  endfunction

endpackage

// File: rtl/mixer_envelope.sv
// Per-voice amplitude envelope: retrigger on note change, decay on tick.
// Decay is present only when SPEAKER_MIXER_ENVELOPE_EN is defined.
module mixer_envelope
  import speaker_pkg::*;
#(
  parameter int unsigned ENV_BITS = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [7:0]          note,
  input  logic                tick,
  output logic [ENV_BITS-1:0] env
);

`ifdef SPEAKER_MIXER_ENVELOPE_EN
  localparam logic [ENV_BITS-1:0] ENV_ONE = ENV_BITS'(1);

  logic [7:0] prev_note;

  // A note change always takes priority over a coincident decay tick.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_note <= NOTE_REST;
      env       <= '0;
    end else begin
      prev_note <= note;
      if (note != prev_note) begin
        env <= is_sounding(note) ? '1 : '0;
      end else if (tick && (env != '0)) begin
        env <= env - ENV_ONE;
      end
    end
  end
`else
  logic unused_tick;
  assign unused_tick = tick;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      env <= '0;
    end else begin
      env <= is_sounding(note) ? '1 : '0;
    end
  end
`endif

endmodule

// File: rtl/speaker_mixer.sv
// Two-voice envelope mixer driving a fixed-period PWM speaker pin.
// Optional decay envelope: define SPEAKER_MIXER_ENVELOPE_EN.
module speaker_mixer
  import speaker_pkg::*;
#(
  parameter int unsigned ENV_BITS  = 4,
  parameter int unsigned DECAY_DIV = 262144
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                voice_b,
  input  logic                voice_m,
  input  logic [7:0]          note_b,
  input  logic [7:0]          note_m,
  input  logic                mute,
  output logic                pwm_out,
  output logic [ENV_BITS:0]   level,
  output logic [ENV_BITS-1:0] env_b,
  output logic [ENV_BITS-1:0] env_m
);

  localparam int unsigned       PWM_TOP  = 2 * ((2 ** ENV_BITS) - 1);
  localparam logic [ENV_BITS:0] PWM_LAST = (ENV_BITS + 1)'(PWM_TOP);
  localparam logic [ENV_BITS:0] CNT_ONE  = (ENV_BITS + 1)'(1);

  logic                voice_b_r, voice_m_r, mute_r;
  logic [7:0]          note_b_r, note_m_r;
  logic                tick;
  logic [ENV_BITS-1:0] amp_b, amp_m;
  logic [ENV_BITS:0]   sum;
  logic [ENV_BITS:0]   pwm_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      voice_b_r <= 1'b0;
      voice_m_r <= 1'b0;
      mute_r    <= 1'b0;
      note_b_r  <= NOTE_REST;
      note_m_r  <= NOTE_REST;
    end else begin
      voice_b_r <= voice_b;
      voice_m_r <= voice_m;
      mute_r    <= mute;
      note_b_r  <= note_b;
      note_m_r  <= note_m;
    end
  end

`ifdef SPEAKER_MIXER_ENVELOPE_EN
  localparam int unsigned PRE_BITS = $clog2(DECAY_DIV);

  logic [PRE_BITS-1:0] presc;

  assign tick = (presc == PRE_BITS'(DECAY_DIV - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else begin
      presc <= tick ? '0 : presc + PRE_BITS'(1);
    end
  end
`else
  localparam int unsigned unused_decay_div = DECAY_DIV;

  assign tick = 1'b0;
`endif

  mixer_envelope #(.ENV_BITS(ENV_BITS)) u_env_b (
    .clock   (clock),
    .reset_n (reset_n),
    .note    (note_b_r),
    .tick    (tick),
    .env     (env_b)
  );

  mixer_envelope #(.ENV_BITS(ENV_BITS)) u_env_m (
    .clock   (clock),
    .reset_n (reset_n),
    .note    (note_m_r),
    .tick    (tick),
    .env     (env_m)
  );

  always_comb begin
    amp_b = voice_b_r ? env_b : '0;
    amp_m = voice_m_r ? env_m : '0;
    sum   = {1'b0, amp_b} + {1'b0, amp_m};
  end

  // Level only changes at the period start so a period is never split.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pwm_cnt <= '0;
      level   <= '0;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + CNT_ONE;
      if (pwm_cnt == '0) begin
        level <= mute_r ? '0 : sum;
      end
      pwm_out <= (pwm_cnt < level);
    end
  end

endmodule

// File: tb/tb_speaker_mixer.sv
// Self-checking bench for speaker_mixer (ENV_BITS=4, DECAY_DIV=4).
module tb_speaker_mixer;

  localparam int ENV_BITS  = 4;
  localparam int DECAY_DIV = 4;
  localparam int ENV_MAX   = 15;
  localparam int PER       = 2 * ENV_MAX + 1;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       voice_b = 1'b0, voice_m = 1'b0, mute = 1'b0;
  logic [7:0] note_b = 8'h00, note_m = 8'h00;
  logic       pwm_out;
  logic [4:0] level;
  logic [3:0] env_b, env_m;

  int checks = 0;
  int failures = 0;

  speaker_mixer #(.ENV_BITS(ENV_BITS), .DECAY_DIV(DECAY_DIV)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .voice_b (voice_b),
    .voice_m (voice_m),
    .note_b  (note_b),
    .note_m  (note_m),
    .mute    (mute),
    .pwm_out (pwm_out),
    .level   (level),
    .env_b   (env_b),
    .env_m   (env_m)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit sounding(input int n);
    return (n != 8'h00) && (n != 8'hFF);
  endfunction

  function automatic int env_rule(input int e, input int n, input int p, input bit tick);
`ifdef SPEAKER_MIXER_ENVELOPE_EN
    if (n != p) return sounding(n) ? ENV_MAX : 0;
    if (tick && e > 0) return e - 1;
    return e;
`else
    return sounding(n) ? ENV_MAX : 0;
`endif
  endfunction

  // Model state after edge mt (mt = edges since reset release).
  int mt, mnb, mnm, mpb, mpm, meb, mem, mvb, mvm, mmute, mlev, mpwm;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mt = 0; mnb = 0; mnm = 0; mpb = 0; mpm = 0; meb = 0; mem = 0;
      mvb = 0; mvm = 0; mmute = 0; mlev = 0; mpwm = 0;
    end else begin
      int phase, sum, nb, nm;
      bit tick;
      tick  = ((mt + 1) % DECAY_DIV) == 0;
      phase = mt % PER;
      sum   = (mvb != 0 ? meb : 0) + (mvm != 0 ? mem : 0);
      mpwm  = (phase < mlev) ? 1 : 0;
      if (phase == 0) mlev = (mmute != 0) ? 0 : sum;
      nb = env_rule(meb, mnb, mpb, tick);
      nm = env_rule(mem, mnm, mpm, tick);
      meb = nb; mem = nm; mpb = mnb; mpm = mnm;
      mnb = note_b; mnm = note_m; mvb = voice_b; mvm = voice_m; mmute = mute;
      mt++;
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      chk("model_pwm_out", pwm_out, mpwm);
      chk("model_level", level, mlev);
      chk("model_env_b", env_b, meb);
      chk("model_env_m", env_m, mem);
    end
  end

  initial begin
    int cnt, mx, mn, n;
    voice_b = 1'b1; voice_m = 1'b1;
    repeat (3) @(negedge clock);
    chk("in_reset_pwm", pwm_out, 0);
    chk("in_reset_level", level, 0);
    reset_n = 1'b1;

    // Idle: voices high but both notes resting.
    cnt = 0; mx = 0;
    repeat (100) begin
      @(negedge clock);
      cnt += pwm_out;
      if (level > mx) mx = level;
    end
    chk("idle_pwm_high_count", cnt, 0);
    chk("idle_level_max", mx, 0);

    // Bass retrigger, melody silent.
    voice_m = 1'b0;
    note_b = 8'h21;
    @(negedge clock);
    chk("retrig_not_early", env_b, 0);
    @(negedge clock);
    chk("retrig_env_b", env_b, ENV_MAX);

`ifdef SPEAKER_MIXER_ENVELOPE_EN
    repeat (20) @(negedge clock);
    while (((mt + 2) % DECAY_DIV) != 0) @(negedge clock);
    note_b = 8'h22;
    @(negedge clock);
    @(negedge clock);
    chk("tick_collision_env_b", env_b, ENV_MAX);
    n = 0;
    while (env_b != 0 && n < 80) begin
      @(negedge clock);
      n++;
    end
    chk("decay_to_zero_cycles", n, 60);
    mx = 0;
    repeat (20) begin
      @(negedge clock);
      if (env_b > mx) mx = env_b;
    end
    chk("decay_hold_zero", mx, 0);
`else
    n = 0;
    while (level == 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("bass_level", level, 15);
    @(negedge clock);
    cnt = 0;
    repeat (PER) begin
      @(negedge clock);
      cnt += pwm_out;
    end
    chk("bass_pwm_high_per_period", cnt, 15);
    voice_m = 1'b1;
    note_m = 8'h40;
    n = 0;
    while (level != 30 && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("both_level", level, 30);
    @(negedge clock);
    cnt = 0;
    repeat (PER) begin
      @(negedge clock);
      cnt += (pwm_out == 1'b0) ? 1 : 0;
    end
    chk("both_pwm_low_per_period", cnt, 1);
`endif

    // Melody to sounding then end-of-song.
    voice_m = 1'b1;
    note_m = 8'h41;
    repeat (2) @(negedge clock);
    chk("melody_retrig", env_m, ENV_MAX);
    note_m = 8'hFF;
    @(negedge clock);
    chk("melody_end_not_early", env_m, ENV_MAX);
    @(negedge clock);
    chk("melody_end_env", env_m, 0);

    // Mute with both voices freshly retriggered.
    note_b = 8'h23; note_m = 8'h42;
    repeat (3) @(negedge clock);
    mute = 1'b1;
    n = 0;
    while (level != 0 && n < 2 * PER) begin
      @(negedge clock);
      n++;
    end
    chk("mute_level", level, 0);
    chk("mute_latency_ok", (n <= PER + 2) ? 1 : 0, 1);
    @(negedge clock);
    cnt = 0;
    repeat (PER) begin
      @(negedge clock);
      cnt += pwm_out;
    end
    chk("mute_pwm_high_count", cnt, 0);

    // Asynchronous reset while the pin is high.
    mute = 1'b0;
    note_b = 8'h24; note_m = 8'h43;
    n = 0;
    while (pwm_out != 1'b1 && n < 80) begin
      @(negedge clock);
      n++;
    end
    chk("saw_pwm_high", pwm_out, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_pwm", pwm_out, 0);
    chk("async_rst_level", level, 0);
    chk("async_rst_env_b", env_b, 0);
    chk("async_rst_env_m", env_m, 0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    chk("post_reset_retrig_b", env_b, ENV_MAX);
    chk("post_reset_retrig_m", env_m, ENV_MAX);

`ifndef SPEAKER_MIXER_ENVELOPE_EN
    mn = ENV_MAX;
    repeat (200) begin
      @(negedge clock);
      if (env_b < mn) mn = env_b;
    end
    chk("no_decay_env_b_min", mn, ENV_MAX);
`endif

    repeat (4) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
